// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers for the single-clock FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_if
// Description : Write/read handshake bundle between FIFO agents and storage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  logic                       w_en;
  logic                       r_en;
  logic [DATA_WIDTH-1:0]      data_in;
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Register-array storage, one sync write port, one registered
//               read port that holds its value when not read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_W-1:0]     wr_idx,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  rd_en,
  input  wire logic [ADDR_W-1:0]     rd_idx,
  output logic      [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage is deliberately not reset; contents are only observed after a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_idx];
    end
  end

  assign rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO: pointers, flags, occupancy, error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input wire logic clk,
  input wire logic rst_n,
  fifo_if.slave    bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_ok;
  logic          w_rd_ok;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) &&
                   (r_wr_ptr[IW] != r_rd_ptr[IW]);

  // A simultaneous read frees a slot, so a write while full is still taken.
  assign w_wr_ok = bus.w_en && (!w_full || bus.r_en);
  assign w_rd_ok = bus.r_en && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_overflow  <= bus.w_en && !w_wr_ok;
      r_underflow <= bus.r_en && !w_rd_ok;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (IW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_ok),
    .wr_idx  (r_wr_ptr[IW-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (w_rd_ok),
    .rd_idx  (r_rd_ptr[IW-1:0]),
    .rd_data (bus.data_out)
  );

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_wr_ptr - r_rd_ptr;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed self-checking bench for sync_fifo (DEPTH=8, 8-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fifo_if #(.DEPTH(8), .DATA_WIDTH(8)) bus ();

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of request, sample 1 time unit after the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] d);
    bus.w_en    = we;
    bus.r_en    = re;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = 8'h00;

    // Reset with no traffic
    #12;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout", 32'(bus.data_out), 32'h00);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
    rst_n = 1'b1;

    // Three writes, three reads, one-cycle read latency
    step(1'b1, 1'b0, 8'h11);
    check("first_wr_count", 32'(bus.count), 32'd1);
    check("first_wr_empty", 32'(bus.empty), 32'd0);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    check("three_count", 32'(bus.count), 32'd3);
    step(1'b0, 1'b1, 8'h00);
    check("rd0", 32'(bus.data_out), 32'h11);
    step(1'b0, 1'b1, 8'h00);
    check("rd1", 32'(bus.data_out), 32'h22);
    step(1'b0, 1'b1, 8'h00);
    check("rd2", 32'(bus.data_out), 32'h33);
    check("rd_done_empty", 32'(bus.empty), 32'd1);
    check("rd_done_unf", 32'(bus.underflow), 32'd0);
    step(1'b0, 1'b0, 8'h00);
    check("idle_hold", 32'(bus.data_out), 32'h33);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd8);
    check("fill_ovf_quiet", 32'(bus.overflow), 32'd0);
    step(1'b1, 1'b0, 8'hAA);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd8);
    step(1'b0, 1'b0, 8'h00);
    check("ovf_once", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("drain", 32'(bus.data_out), 32'(i));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_full", 32'(bus.full), 32'd0);

    // Simultaneous write+read while full
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'h99);
    check("fullrw_dout", 32'(bus.data_out), 32'h01);
    check("fullrw_count", 32'(bus.count), 32'd8);
    check("fullrw_full", 32'(bus.full), 32'd1);
    check("fullrw_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("fullrw_drain", 32'(bus.data_out), 32'(i));
    end
    step(1'b0, 1'b1, 8'h00);
    check("fullrw_last", 32'(bus.data_out), 32'h99);
    check("fullrw_empty", 32'(bus.empty), 32'd1);

    // Underflow cases
    step(1'b0, 1'b1, 8'h00);
    check("unf_pulse", 32'(bus.underflow), 32'd1);
    check("unf_hold", 32'(bus.data_out), 32'h99);
    step(1'b1, 1'b1, 8'h5A);
    check("unf_rw_pulse", 32'(bus.underflow), 32'd1);
    check("unf_rw_count", 32'(bus.count), 32'd1);
    check("unf_rw_hold", 32'(bus.data_out), 32'h99);
    step(1'b0, 1'b0, 8'h00);
    check("unf_clear", 32'(bus.underflow), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("unf_rw_read", 32'(bus.data_out), 32'h5A);

    // Streaming with occupancy 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i));
    for (int i = 3; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(i));
      check("stream", 32'(bus.data_out), 32'(i - 3));
      check("stream_count", 32'(bus.count), 32'd3);
    end
    for (int i = 17; i < 20; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("stream_tail", 32'(bus.data_out), 32'(i));
    end
    check("stream_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    check("pre_rst_count", 32'(bus.count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_full", 32'(bus.full), 32'd0);
    check("arst_dout", 32'(bus.data_out), 32'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hC3);
    check("post_rst_count", 32'(bus.count), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_read", 32'(bus.data_out), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
